hazard_stall_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage CPU; sits beside the forwarding unit and drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX and EX/MEM.
- Detects load-use hazards that forwarding cannot cover.
- Sequences multi-cycle mul/div occupancy of EX via an internal counter.
- Flushes wrong-path instructions on a taken branch.
- Keeps a saturating stall-cycle statistic.

---
 rtl/hazard_pkg.sv | 48 ++++
 rtl/hazard_stall_ctrl_load_use_detect.sv | 29 ++
 rtl/hazard_stall_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// The control vector bundles every pipeline-register control into one assignable value.
package hazard_pkg;

    localparam int DEFAULT_REG_BITS = 4;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic idex_bubble;
        logic exmem_bubble;
        logic ifid_flush;
        logic idex_flush;
        logic busy;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
        idex_bubble: 1'b0, exmem_bubble: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, busy: 1'b0
    };

    // Mul/div holds EX: freeze the front end and feed bubbles into MEM.
    localparam ctrl_t CTRL_HOLD = '{
        pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
        idex_bubble: 1'b0, exmem_bubble: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, busy: 1'b1
    };

    localparam ctrl_t CTRL_FLUSH = '{
        pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
        idex_bubble: 1'b0, exmem_bubble: 1'b0,
        ifid_flush: 1'b1, idex_flush: 1'b1, busy: 1'b0
    };

    localparam ctrl_t CTRL_LOAD_STALL = '{
        pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b1,
        idex_bubble: 1'b1, exmem_bubble: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, busy: 1'b0
    };

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Combinational load-use comparator: the IF/ID consumer reads the register
// that the load currently in ID/EX has not yet produced.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_BITS        = DEFAULT_REG_BITS,
    parameter int ZERO_REG_IGNORE = 0
) (
    input  logic [REG_BITS-1:0] rs1,
    input  logic [REG_BITS-1:0] rs2,
    input  logic                use_rs1,
    input  logic                use_rs2,
    input  logic [REG_BITS-1:0] rd_load,
    input  logic                mem_read,
    input  logic                reg_write,
    output logic                load_use
);

    logic rs1_hit;
    logic rs2_hit;
    logic zero_dest;

    assign rs1_hit   = use_rs1 && (rs1 == rd_load);
    assign rs2_hit   = use_rs2 && (rs2 == rd_load);
    // With a hard-wired zero register a load "to r0" produces nothing to wait for.
    assign zero_dest = (ZERO_REG_IGNORE != 0) && (rd_load == '0);
    assign load_use  = mem_read && reg_write && (rs1_hit || rs2_hit) && !zero_dest;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage pipeline: branch flush, mul/div EX
// occupancy, load-use stall and a saturating stall-cycle statistic.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_BITS        = DEFAULT_REG_BITS,
    parameter int MULDIV_LATENCY  = 4,
    parameter int ZERO_REG_IGNORE = 0,
    parameter int STALL_CNT_BITS  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_BITS-1:0]       r1IFID,
    input  logic [REG_BITS-1:0]       r2IFID,
    input  logic                      useR1IFID,
    input  logic                      useR2IFID,
    input  logic [REG_BITS-1:0]       r12IDEX,
    input  logic                      memReadIDEX,
    input  logic                      regWriteIDEX,
    input  logic                      mulDivEX,
    input  logic                      branchTakenEX,
    output logic                      pcWrite,
    output logic                      ifidWrite,
    output logic                      idexWrite,
    output logic                      idexBubble,
    output logic                      exmemBubble,
    output logic                      ifidFlush,
    output logic                      idexFlush,
    output logic                      busy,
    output logic [STALL_CNT_BITS-1:0] stallCycles
);

    localparam int CNT_W = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY) : 1;
    localparam int CNT_LOAD_INT = (MULDIV_LATENCY > 1) ? MULDIV_LATENCY - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_LOAD_INT);
    localparam bit MULDIV_STALLS = (MULDIV_LATENCY > 1);

    logic [0:0]                state_q;
    logic [0:0]                state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic [STALL_CNT_BITS-1:0] stall_cnt_q;
    logic [STALL_CNT_BITS-1:0] stall_cnt_d;
    logic                      load_use;
    ctrl_t                     ctrl;

    load_use_detect #(
        .REG_BITS       (REG_BITS),
        .ZERO_REG_IGNORE(ZERO_REG_IGNORE)
    ) u_load_use_detect (
        .rs1      (r1IFID),
        .rs2      (r2IFID),
        .use_rs1  (useR1IFID),
        .use_rs2  (useR2IFID),
        .rd_load  (r12IDEX),
        .mem_read (memReadIDEX),
        .reg_write(regWriteIDEX),
        .load_use (load_use)
    );

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        ctrl        = CTRL_DEFAULT;
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (!rst) begin
            case (state_q)
                ST_BUSY: begin
                    if (cnt_q != '0) begin
                        ctrl  = CTRL_HOLD;
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        // Release cycle: the mul/div moves on to MEM, so a new mulDivEX is not acted on yet.
                        state_d = ST_RUN;
                        if (branchTakenEX) begin
                            ctrl = CTRL_FLUSH;
                        end else if (load_use) begin
                            ctrl = CTRL_LOAD_STALL;
                        end
                    end
                end
                default: begin
                    if (branchTakenEX) begin
                        ctrl = CTRL_FLUSH;
                    end else if (MULDIV_STALLS && mulDivEX) begin
                        ctrl    = CTRL_HOLD;
                        cnt_d   = CNT_LOAD;
                        state_d = ST_BUSY;
                    end else if (load_use) begin
                        ctrl = CTRL_LOAD_STALL;
                    end
                end
            endcase

            if (!ctrl.pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pcWrite     = ctrl.pc_write;
    assign ifidWrite   = ctrl.ifid_write;
    assign idexWrite   = ctrl.idex_write;
    assign idexBubble  = ctrl.idex_bubble;
    assign exmemBubble = ctrl.exmem_bubble;
    assign ifidFlush   = ctrl.ifid_flush;
    assign idexFlush   = ctrl.idex_flush;
    assign busy        = ctrl.busy;
    assign stallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: three controller variants share one stimulus stream and
// are compared each cycle against a cycle-occupancy reference model.
module tb_hazard_stall_ctrl;

    localparam logic [7:0] E_DEF   = 8'b1110_0000;
    localparam logic [7:0] E_HOLD  = 8'b0000_1001;
    localparam logic [7:0] E_FLUSH = 8'b1110_0110;
    localparam logic [7:0] E_STALL = 8'b0011_0000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] r1IFID, r2IFID, r12IDEX;
    logic       useR1IFID, useR2IFID, memReadIDEX, regWriteIDEX, mulDivEX, branchTakenEX;

    wire [7:0]  c0, c1, c2;
    wire [15:0] s0, s1, s2;

    int lat_p [3] = '{4, 1, 3};
    int zri_p [3] = '{0, 1, 0};
    int age   [3] = '{0, 0, 0};
    int stl   [3] = '{0, 0, 0};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_BITS(4), .MULDIV_LATENCY(4), .ZERO_REG_IGNORE(0), .STALL_CNT_BITS(16)) u_l4 (
        .clk(clk), .rst(rst), .r1IFID(r1IFID), .r2IFID(r2IFID), .useR1IFID(useR1IFID),
        .useR2IFID(useR2IFID), .r12IDEX(r12IDEX), .memReadIDEX(memReadIDEX),
        .regWriteIDEX(regWriteIDEX), .mulDivEX(mulDivEX), .branchTakenEX(branchTakenEX),
        .pcWrite(c0[7]), .ifidWrite(c0[6]), .idexWrite(c0[5]), .idexBubble(c0[4]),
        .exmemBubble(c0[3]), .ifidFlush(c0[2]), .idexFlush(c0[1]), .busy(c0[0]),
        .stallCycles(s0));

    hazard_stall_ctrl #(.REG_BITS(4), .MULDIV_LATENCY(1), .ZERO_REG_IGNORE(1), .STALL_CNT_BITS(16)) u_l1 (
        .clk(clk), .rst(rst), .r1IFID(r1IFID), .r2IFID(r2IFID), .useR1IFID(useR1IFID),
        .useR2IFID(useR2IFID), .r12IDEX(r12IDEX), .memReadIDEX(memReadIDEX),
        .regWriteIDEX(regWriteIDEX), .mulDivEX(mulDivEX), .branchTakenEX(branchTakenEX),
        .pcWrite(c1[7]), .ifidWrite(c1[6]), .idexWrite(c1[5]), .idexBubble(c1[4]),
        .exmemBubble(c1[3]), .ifidFlush(c1[2]), .idexFlush(c1[1]), .busy(c1[0]),
        .stallCycles(s1));

    hazard_stall_ctrl #(.REG_BITS(4), .MULDIV_LATENCY(3), .ZERO_REG_IGNORE(0), .STALL_CNT_BITS(16)) u_l3 (
        .clk(clk), .rst(rst), .r1IFID(r1IFID), .r2IFID(r2IFID), .useR1IFID(useR1IFID),
        .useR2IFID(useR2IFID), .r12IDEX(r12IDEX), .memReadIDEX(memReadIDEX),
        .regWriteIDEX(regWriteIDEX), .mulDivEX(mulDivEX), .branchTakenEX(branchTakenEX),
        .pcWrite(c2[7]), .ifidWrite(c2[6]), .idexWrite(c2[5]), .idexBubble(c2[4]),
        .exmemBubble(c2[3]), .ifidFlush(c2[2]), .idexFlush(c2[1]), .busy(c2[0]),
        .stallCycles(s2));

    function automatic logic [7:0] get_c(input int k);
        case (k)
            0:       return c0;
            1:       return c1;
            default: return c2;
        endcase
    endfunction

    function automatic logic [15:0] get_s(input int k);
        case (k)
            0:       return s0;
            1:       return s1;
            default: return s2;
        endcase
    endfunction

    function automatic bit lu(input int k);
        bit hit;
        hit = (useR1IFID && r1IFID == r12IDEX) || (useR2IFID && r2IFID == r12IDEX);
        if (zri_p[k] != 0 && r12IDEX == 4'd0) return 1'b0;
        return memReadIDEX && regWriteIDEX && hit;
    endfunction

    // age = number of EX cycles the current mul/div has already spent stalled (0: none in flight).
    function automatic void model_eval(input int k, output logic [7:0] e, output int na, output int ns);
        bit release_cyc;
        e  = E_DEF;
        na = 0;
        ns = stl[k];
        if (rst) begin
            ns = 0;
        end else begin
            if (age[k] >= 1 && age[k] < lat_p[k] - 1) begin
                e  = E_HOLD;
                na = age[k] + 1;
            end else begin
                release_cyc = (age[k] >= 1);
                if (branchTakenEX) begin
                    e = E_FLUSH;
                end else if (!release_cyc && mulDivEX && lat_p[k] > 1) begin
                    e  = E_HOLD;
                    na = 1;
                end else if (lu(k)) begin
                    e = E_STALL;
                end
            end
            if (e[7] == 1'b0 && stl[k] < 65535) ns = stl[k] + 1;
        end
    endfunction

    task automatic step();
        logic [7:0] exp_c [3];
        int         nage  [3];
        int         nstl  [3];
        logic [7:0]  got_c;
        logic [15:0] got_s;
        #1;
        assert (!(mulDivEX && (memReadIDEX || branchTakenEX)))
            else $error("illegal stimulus at cycle %0d: mulDivEX with load or branch", cyc);
        for (int k = 0; k < 3; k++) begin
            model_eval(k, exp_c[k], nage[k], nstl[k]);
            got_c = get_c(k);
            got_s = get_s(k);
            n_checks++;
            assert (got_c === exp_c[k]) else begin
                n_fail++;
                $error("FAIL ctrl[inst %0d] cycle %0d: observed %b expected %b", k, cyc, got_c, exp_c[k]);
            end
            n_checks++;
            assert (got_s === 16'(stl[k])) else begin
                n_fail++;
                $error("FAIL stallCycles[inst %0d] cycle %0d: observed %0d expected %0d", k, cyc, got_s, stl[k]);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            age[k] = nage[k];
            stl[k] = nstl[k];
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        r1IFID = 4'd0; r2IFID = 4'd0; r12IDEX = 4'd0;
        useR1IFID = 1'b0; useR2IFID = 1'b0; memReadIDEX = 1'b0; regWriteIDEX = 1'b0;
        mulDivEX = 1'b0; branchTakenEX = 1'b0;
    endtask

    task automatic set_load_use(input logic [3:0] rd, input logic [3:0] rs1, input logic wr, input logic u1);
        r12IDEX = rd; r1IFID = rs1; regWriteIDEX = wr; useR1IFID = u1;
        memReadIDEX = 1'b1; useR2IFID = 1'b0; r2IFID = 4'd9;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);

        // Reset state, then the basic load-use stall followed by defaults.
        step();
        rst = 1'b0;
        step();
        set_load_use(4'd1, 4'd1, 1'b1, 1'b1); step();
        idle_inputs(); step();

        // No-hazard variants, then a load to r0 (ignored only by the ZERO_REG_IGNORE variant).
        set_load_use(4'd1, 4'd1, 1'b0, 1'b1); step();
        set_load_use(4'd1, 4'd1, 1'b1, 1'b0); step();
        set_load_use(4'd1, 4'd3, 1'b1, 1'b1); step();
        set_load_use(4'd0, 4'd0, 1'b1, 1'b1); step();
        idle_inputs(); step();

        // Mul/div held in EX, then released.
        mulDivEX = 1'b1;
        repeat (4) step();
        mulDivEX = 1'b0; step(); step();

        // Branch beats a simultaneous load-use.
        set_load_use(4'd2, 4'd2, 1'b1, 1'b1); branchTakenEX = 1'b1; step();
        idle_inputs(); step();

        // Load-use presented on the LAT=3 release cycle.
        mulDivEX = 1'b1; step();
        step();
        mulDivEX = 1'b0; set_load_use(4'd5, 4'd5, 1'b1, 1'b1); step();
        idle_inputs(); step(); step();

        // Reset in the second BUSY cycle drops the hold without a release cycle.
        mulDivEX = 1'b1; step(); step();
        rst = 1'b1; step();
        rst = 1'b0; mulDivEX = 1'b0; step(); step();

        // Randomized traffic over a small register range so hazards are frequent.
        for (int i = 0; i < 600; i++) begin
            r1IFID        = 4'($urandom_range(0, 3));
            r2IFID        = 4'($urandom_range(0, 3));
            r12IDEX       = 4'($urandom_range(0, 3));
            useR1IFID     = 1'($urandom_range(0, 1));
            useR2IFID     = 1'($urandom_range(0, 1));
            memReadIDEX   = 1'($urandom_range(0, 1));
            regWriteIDEX  = 1'($urandom_range(0, 1));
            mulDivEX      = ($urandom_range(0, 5) == 0);
            branchTakenEX = ($urandom_range(0, 7) == 0);
            if (mulDivEX) begin
                memReadIDEX   = 1'b0;
                branchTakenEX = 1'b0;
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
        end

        // Saturation: a continuous load-use stall from a cleared counter runs past all-ones.
        idle_inputs(); rst = 1'b1; step();
        rst = 1'b0;
        set_load_use(4'd1, 4'd1, 1'b1, 1'b1);
        repeat (65537) step();
        idle_inputs(); step();
        n_checks++;
        assert (s0 === 16'hFFFF) else begin
            n_fail++;
            $error("FAIL saturate: observed %h expected ffff", s0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
